// File: rtl/pwm_sequencer.sv
// Table-driven PWM sequencer: each entry plays `per` ticks with `hold` high ticks,
// repeated `reps` times, then the sequencer advances, wraps (loop) or finishes.
module pwm_sequencer #(
  parameter int PRESCALE_TICKS = 600,
  parameter int STEPS          = 4,
  parameter int W              = 16,
  parameter int RW             = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     stop,
  input  logic                     loop,
  input  logic                     cfg_we,
  input  logic [$clog2(STEPS)-1:0] cfg_addr,
  input  logic [W-1:0]             cfg_period,
  input  logic [W-1:0]             cfg_hold,
  input  logic [RW-1:0]            cfg_reps,
  output logic                     pwm,
  output logic                     busy,
  output logic [$clog2(STEPS)-1:0] step,
  output logic                     done
);
  localparam int SW = $clog2(STEPS);
  localparam int PW = $clog2(PRESCALE_TICKS);
  localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE_TICKS - 1);
  localparam logic [SW-1:0] STEP_LAST  = SW'(STEPS - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [SW-1:0]   step_q, step_d;
  logic [W-1:0]    per_q, per_d;
  logic [W-1:0]    hold_q, hold_d;
  logic [RW-1:0]   reps_q, reps_d;
  logic [W-1:0]    cnt_q, cnt_d;
  logic [RW-1:0]   rep_q, rep_d;
  logic [PW-1:0]   presc_q, presc_d;
  logic            pwm_q, pwm_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  logic [W-1:0]    tbl_per_q  [STEPS];
  logic [W-1:0]    tbl_per_d  [STEPS];
  logic [W-1:0]    tbl_hold_q [STEPS];
  logic [W-1:0]    tbl_hold_d [STEPS];
  logic [RW-1:0]   tbl_reps_q [STEPS];
  logic [RW-1:0]   tbl_reps_d [STEPS];

  logic            tick_s;
  logic            addr_ok_s;
  logic [RW:0]     eff_reps_s;
  logic [RW:0]     rep_next_s;

  // Host table writes land in any state; the running segment works from its own copies.
  always_comb begin
    tbl_per_d  = tbl_per_q;
    tbl_hold_d = tbl_hold_q;
    tbl_reps_d = tbl_reps_q;
    addr_ok_s  = ({1'b0, cfg_addr} < (SW+1)'(STEPS));
    if (cfg_we && addr_ok_s) begin
      tbl_per_d[cfg_addr]  = cfg_period;
      tbl_hold_d[cfg_addr] = cfg_hold;
      tbl_reps_d[cfg_addr] = cfg_reps;
    end else begin
      tbl_per_d  = tbl_per_q;
    end
  end

  // Sequencing: next state, counters and the registered outputs' next values.
  always_comb begin
    state_d    = state_q;
    step_d     = step_q;
    per_d      = per_q;
    hold_d     = hold_q;
    reps_d     = reps_q;
    cnt_d      = cnt_q;
    rep_d      = rep_q;
    presc_d    = presc_q;
    pwm_d      = pwm_q;
    tick_s     = (presc_q == PRESC_LAST);
    // rep compares one bit wider so reps = all-ones cannot wrap
    eff_reps_s = (reps_q == '0) ? (RW+1)'(1) : {1'b0, reps_q};
    rep_next_s = {1'b0, rep_q} + (RW+1)'(1);

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_LOAD;
          step_d  = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOAD: begin
        per_d   = tbl_per_q[step_q];
        hold_d  = tbl_hold_q[step_q];
        reps_d  = tbl_reps_q[step_q];
        cnt_d   = '0;
        rep_d   = '0;
        presc_d = '0;
        if (tbl_per_q[step_q] == '0) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        pwm_d = (cnt_q < hold_q);
        if (!tick_s) begin
          presc_d = presc_q + PW'(1);
        end else if (cnt_q != per_q - W'(1)) begin
          presc_d = '0;
          cnt_d   = cnt_q + W'(1);
        end else begin
          presc_d = '0;
          cnt_d   = '0;
          if (rep_next_s < eff_reps_s) begin
            rep_d = rep_q + RW'(1);
          end else if (step_q != STEP_LAST) begin
            step_d  = step_q + SW'(1);
            state_d = ST_LOAD;
          end else if (loop) begin
            step_d  = '0;
            state_d = ST_LOAD;
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // stop wins over everything, including a segment end in the same cycle
    if (stop) begin
      state_d = ST_IDLE;
      step_d  = step_q;
    end else begin
      step_d  = step_d;
    end

    if ((state_d == ST_IDLE) || (state_d == ST_DONE)) begin
      pwm_d = 1'b0;
    end else begin
      pwm_d = pwm_d;
    end
    busy_d = (state_d == ST_LOAD) || (state_d == ST_RUN);
    done_d = (state_d == ST_DONE);
  end

  // All state, including the table, clears on reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      step_q  <= '0;
      per_q   <= '0;
      hold_q  <= '0;
      reps_q  <= '0;
      cnt_q   <= '0;
      rep_q   <= '0;
      presc_q <= '0;
      pwm_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      for (int i = 0; i < STEPS; i++) begin
        tbl_per_q[i]  <= '0;
        tbl_hold_q[i] <= '0;
        tbl_reps_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      step_q     <= step_d;
      per_q      <= per_d;
      hold_q     <= hold_d;
      reps_q     <= reps_d;
      cnt_q      <= cnt_d;
      rep_q      <= rep_d;
      presc_q    <= presc_d;
      pwm_q      <= pwm_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      tbl_per_q  <= tbl_per_d;
      tbl_hold_q <= tbl_hold_d;
      tbl_reps_q <= tbl_reps_d;
    end
  end

  assign pwm  = pwm_q;
  assign busy = busy_q;
  assign step = step_q;
  assign done = done_q;

endmodule

// File: tb/tb_pwm_sequencer.sv
// Self-checking bench: expected waveforms are expanded from the table contents
// (segment x repeat x period x tick) and compared cycle by cycle.
module tb_pwm_sequencer;
  localparam int P     = 4;
  localparam int STEPS = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       start, stop, loop, cfg_we;
  logic [1:0] cfg_addr;
  logic [7:0] cfg_period, cfg_hold;
  logic [3:0] cfg_reps;
  logic       pwm, busy, done;
  logic [1:0] step;

  int n_assert = 0;
  int n_fail   = 0;

  logic [7:0] mper  [STEPS];
  logic [7:0] mhold [STEPS];
  logic [3:0] mreps [STEPS];

  typedef struct packed {
    logic       pwm_e;
    logic       busy_e;
    logic       done_e;
    logic [1:0] step_e;
    logic       drop_e;
  } exp_t;
  exp_t q[$];

  pwm_sequencer #(.PRESCALE_TICKS(P), .STEPS(STEPS), .W(8), .RW(4)) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .loop(loop),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_period(cfg_period),
    .cfg_hold(cfg_hold), .cfg_reps(cfg_reps),
    .pwm(pwm), .busy(busy), .step(step), .done(done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cfg_write(input int a, input int per, input int hold, input int reps);
    cfg_addr   = 2'(a);
    cfg_period = 8'(per);
    cfg_hold   = 8'(hold);
    cfg_reps   = 4'(reps);
    cfg_we     = 1'b1;
    tick();
    cfg_we     = 1'b0;
    mper[a]    = 8'(per);
    mhold[a]   = 8'(hold);
    mreps[a]   = 4'(reps);
  endtask

  function automatic void push_e(input logic p, input logic b, input logic d, input int s, input logic dr);
    exp_t e;
    e.pwm_e  = p;
    e.busy_e = b;
    e.done_e = d;
    e.step_e = 2'(s);
    e.drop_e = dr;
    q.push_back(e);
  endfunction

  // Expected per-cycle view from the first LOAD to DONE; pwm lags its cnt by one clock.
  task automatic build(input int npass, input bit wr_en, input int wper, input int whold, input int wreps);
    logic last;
    int   nr, len, c;
    q.delete();
    last = 1'b0;
    for (int p = 0; p < npass; p++) begin
      if (p == 1 && wr_en) begin
        mper[0]  = 8'(wper);
        mhold[0] = 8'(whold);
        mreps[0] = 4'(wreps);
      end
      for (int s = 0; s < STEPS; s++) begin
        push_e(last, 1'b1, 1'b0, s, (npass > 1) && (p == npass - 1) && (s == 2));
        if (mper[s] == 8'd0) begin
          push_e(1'b0, 1'b0, 1'b1, s, 1'b0);
          return;
        end
        nr  = (mreps[s] == 4'd0) ? 1 : int'(mreps[s]);
        len = int'(mper[s]) * nr * P;
        push_e(last, 1'b1, 1'b0, s, 1'b0);
        for (int i = 0; i < len; i++) begin
          c = (i / P) % int'(mper[s]);
          if (i < len - 1) push_e(c < int'(mhold[s]), 1'b1, 1'b0, s, 1'b0);
          else last = (c < int'(mhold[s]));
        end
      end
    end
    push_e(1'b0, 1'b0, 1'b1, STEPS - 1, 1'b0);
  endtask

  task automatic run(input int npass, input bit wr_en, input int wper, input int whold, input int wreps);
    build(npass, wr_en, wper, whold, wreps);
    loop  = (npass > 1);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < q.size(); k++) begin
      check("pwm",  32'(pwm),  32'(q[k].pwm_e));
      check("busy", 32'(busy), 32'(q[k].busy_e));
      check("done", 32'(done), 32'(q[k].done_e));
      check("step", 32'(step), 32'(q[k].step_e));
      if (q[k].drop_e) loop = 1'b0;
      if (wr_en && k == 5) begin
        cfg_addr   = 2'd0;
        cfg_period = 8'(wper);
        cfg_hold   = 8'(whold);
        cfg_reps   = 4'(wreps);
        cfg_we     = 1'b1;
      end else begin
        cfg_we     = 1'b0;
      end
      tick();
    end
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_done", 32'(done), 32'd0);
    check("idle_pwm",  32'(pwm),  32'd0);
    loop = 1'b0;
  endtask

  initial begin
    int n;
    reset = 1'b1; start = 1'b0; stop = 1'b0; loop = 1'b0; cfg_we = 1'b0;
    cfg_addr = 2'd0; cfg_period = 8'd0; cfg_hold = 8'd0; cfg_reps = 4'd0;
    for (int i = 0; i < STEPS; i++) begin
      mper[i] = 8'd0; mhold[i] = 8'd0; mreps[i] = 4'd0;
    end

    // reset state
    repeat (3) tick();
    check("rst_pwm",  32'(pwm),  32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_step", 32'(step), 32'd0);
    reset = 1'b0;
    tick();
    check("idle_pwm0",  32'(pwm),  32'd0);
    check("idle_busy0", 32'(busy), 32'd0);

    // empty table: LOAD then DONE
    run(1, 1'b0, 0, 0, 0);

    // single segment 3/1 x2 followed by a terminator
    cfg_write(0, 3, 1, 2);
    run(1, 1'b0, 0, 0, 0);

    // boundaries: hold 0, hold > per, reps 0, through to the last step
    cfg_write(0, 3, 0, 2);
    cfg_write(1, 3, 5, 1);
    cfg_write(2, 2, 1, 0);
    cfg_write(3, 2, 1, 1);
    run(1, 1'b0, 0, 0, 0);
    cfg_write(2, 2, 1, 1);
    run(1, 1'b0, 0, 0, 0);

    // maximum repeat count
    cfg_write(0, 2, 1, 15);
    cfg_write(1, 0, 0, 0);
    run(1, 1'b0, 0, 0, 0);

    // looping, loop dropped during step 2 of the final pass
    cfg_write(0, 1, 1, 1);
    cfg_write(1, 2, 1, 1);
    cfg_write(2, 1, 0, 2);
    cfg_write(3, 2, 2, 1);
    run(3, 1'b0, 0, 0, 0);

    // rewrite entry 0 while it plays; the new hold shows on the next pass
    cfg_write(0, 3, 1, 1);
    run(2, 1'b1, 3, 2, 1);

    // random tables
    for (int it = 0; it < 8; it++) begin
      for (int s = 0; s < STEPS; s++)
        cfg_write(s, (s == 0) ? $urandom_range(1, 5) : $urandom_range(0, 5),
                  $urandom_range(0, 6), $urandom_range(0, 3));
      run(1, 1'b0, 0, 0, 0);
    end

    // stop in step 1
    cfg_write(0, 2, 1, 1);
    cfg_write(1, 3, 2, 2);
    cfg_write(2, 2, 1, 1);
    cfg_write(3, 2, 1, 1);
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (step !== 2'd1 && n < 200) begin
      tick();
      n++;
    end
    check("reach_step1", 32'(n < 200), 32'd1);
    repeat (5) tick();
    check("pre_stop_busy", 32'(busy), 32'd1);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("stop_pwm",  32'(pwm),  32'd0);
    check("stop_busy", 32'(busy), 32'd0);
    check("stop_done", 32'(done), 32'd0);
    check("stop_step", 32'(step), 32'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stop_nodone", 32'(done), 32'd0);
      check("stop_idle",   32'(busy), 32'd0);
    end
    start = 1'b1;
    stop  = 1'b1;
    tick();
    start = 1'b0;
    stop  = 1'b0;
    check("startstop_busy", 32'(busy), 32'd0);
    check("startstop_step", 32'(step), 32'd1);
    tick();
    check("startstop_busy2", 32'(busy), 32'd0);
    check("startstop_done",  32'(done), 32'd0);

    // asynchronous reset mid-RUN on a constant-high segment
    cfg_write(0, 4, 7, 3);
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (5) tick();
    check("pre_rst_pwm",  32'(pwm),  32'd1);
    check("pre_rst_busy", 32'(busy), 32'd1);
    #3;
    reset = 1'b1;
    #1;
    check("arst_pwm",  32'(pwm),  32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_step", 32'(step), 32'd0);
    #1;
    reset = 1'b0;
    tick();
    for (int i = 0; i < STEPS; i++) begin
      mper[i] = 8'd0; mhold[i] = 8'd0; mreps[i] = 4'd0;
    end
    run(1, 1'b0, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/pwm_sequencer.md
Name: pwm_sequencer

Overview:
- Drives one PWM output through a programmable table of up to STEPS segments.
- Each segment has a period, a hold (high) time and a repeat count, all measured in prescaled ticks.
- Used next to the dual timer for blink patterns and status codes that a fixed period/duty cannot express. Examples: "3 short, 1 long", or fade-like duty ramps.
- Table is written by the host through a simple write port. Sequencing is started and stopped by pulses.

Parameters:
- PRESCALE_TICKS, 600: clk cycles per tick. 25 us at 24 MHz. Must be >= 2.
- STEPS, 4: number of table entries. Must be >= 2.
- W, 16: width of the period and hold fields.
- RW, 8: width of the repeat-count field.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  begin sequence at step 0; sampled only in IDLE
- stop  in  1  abort to IDLE; sampled in every state; priority over start
- loop  in  1  when 1, wrap from the last step to step 0 instead of finishing
- cfg_we  in  1  table write strobe
- cfg_addr  in  $clog2(STEPS)  table index
- cfg_period  in  W  segment period in ticks; 0 = terminator
- cfg_hold  in  W  high ticks per period
- cfg_reps  in  RW  periods per segment; 0 treated as 1
- pwm  out  1  PWM output, registered
- busy  out  1  high in LOAD and RUN
- step  out  $clog2(STEPS)  index of the active entry
- done  out  1  one-cycle pulse on normal completion

Behaviour:
- Reset (asynchronous, active-high):
  - state = IDLE; pwm = 0, busy = 0, done = 0, step = 0.
  - All table entries, working registers, prescaler and counters = 0.
- Table writes:
  - On a clk edge with cfg_we = 1, entry[cfg_addr] <= {cfg_period, cfg_hold, cfg_reps}.
  - Writes are accepted in any state.
  - The running segment uses working copies latched in LOAD. A write to the active entry takes effect at that entry's next LOAD.
- IDLE:
  - pwm = 0, busy = 0.
  - start = 1 and stop = 0 -> LOAD with step = 0.
- LOAD (exactly 1 cycle):
  - Latch entry[step] into per, hold, reps; set cnt = 0, rep = 0, prescaler = 0.
  - per == 0 -> DONE. Otherwise -> RUN.
- RUN, prescaler:
  - Counts 0..PRESCALE_TICKS-1. tick = (prescaler == PRESCALE_TICKS-1).
  - Prescaler wraps to 0 on tick.
- RUN, on tick:
  - cnt < per-1: cnt <= cnt + 1.
  - cnt == per-1: cnt <= 0 and the period ends. If rep + 1 < max(reps, 1), then rep <= rep + 1. Otherwise the segment ends.
- Segment end:
  - step < STEPS-1: step <= step+1 -> LOAD.
  - step == STEPS-1 and loop = 1: step <= 0 -> LOAD.
  - step == STEPS-1 and loop = 0: -> DONE.
- pwm in RUN:
  - pwm <= (cnt < hold), one clk behind cnt.
  - hold = 0 gives a constant-low segment.
  - hold >= per gives a constant-high segment.
  - pwm holds its last RUN value through the 1-cycle LOAD.
  - The first RUN cycle after LOAD drives pwm from cnt = 0.
- Segment timing:
  - A segment lasts per * max(reps,1) * PRESCALE_TICKS clk cycles in RUN, plus 1 LOAD cycle.
- DONE (1 cycle):
  - done = 1, pwm = 0, busy = 0, step holds its last value -> IDLE.
  - done is 0 in all other states.
- stop:
  - stop = 1 in any state: next state IDLE, pwm = 0, busy = 0.
  - No done pulse; step holds its last value.
  - stop in the same cycle as start -> remains IDLE.
- start outside IDLE is ignored; there is no restart mid-sequence.
- loop is sampled only at the end of the last step, so changing it mid-sequence is legal.
- Width rules:
  - cnt and hold compare as W-bit unsigned; rep is RW bits.
  - reps = 2^RW-1 gives the maximum repeat count, with no overflow.
- Reset asserted mid-RUN: immediate IDLE with pwm = 0; table contents are lost.

Test Plan:
All scenarios use PRESCALE_TICKS=4, STEPS=4, W=8, RW=4.
- Reset, then idle: pwm = 0, busy = 0, done = 0, step = 0. Pulse start with the table all zeros -> LOAD, then DONE. done is high exactly 1 cycle, at the 2nd edge after start.
- Single segment: entry0 = {per 3, hold 1, reps 2}, entry1 per = 0, start.
  - pwm pattern is high 4 clk, low 8 clk, repeated twice.
  - Then LOAD step=1, DONE, done pulse; total RUN = 24 clk.
- Boundaries: hold = 0 -> pwm stays 0 for the full segment. hold = 5 with per = 3 -> pwm stays 1. reps = 0 behaves identically to reps = 1.
- Loop: all 4 entries have nonzero period and loop = 1.
  - step sequence is 0,1,2,3,0,1 with no done pulse.
  - Drop loop during step 2 -> done pulses after step 3 ends.
- stop mid-RUN in step 1 -> next cycle pwm = 0, busy = 0, no done. Assert start and stop together in IDLE -> remains IDLE.
- Write entry0 hold from 1 to 2 while step 0 runs: the current segment is unchanged. With loop = 1, the next pass through step 0 shows high for 8 clk per period.
- Assert reset asynchronously mid-RUN: pwm and busy drop before the next clk edge. Table reads back as zero-period, so start -> immediate done.
